const_mul_recon_47: RTL and testbench
=====================================

# const_mul_recon_47

Sequential reconstruction unit for the constant-division datapath. It takes a quotient `q` and remainder `r` from the divide-by-47 slice and rebuilds the dividend `x = q*47 + r`. The computation runs digit-serially, 6 bits per cycle, LSB-first. It sits beside the divider as its inverse: it generates reference dividends for divider stimulus and checks divider results in-system.

## Interface
- `W`, 60: dividend/quotient width; must be a multiple of `CHUNK`.
- `CHUNK`, 6: digit width processed per cycle.
- `DIVISOR`, 47: constant multiplier; must satisfy `DIVISOR < 2**CHUNK`.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  unit can accept a request.
- `in_q`  in  W  quotient.
- `in_r`  in  CHUNK  remainder.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_x`  out  W  low W bits of `q*DIVISOR + r`.
- `out_ovf`  out  1  true result is ≥ 2**W.
- `out_rem_err`  out  1  `in_r >= DIVISOR` was presented.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: `in_ready`=1, `out_valid`=0, `out_x`=0, `out_ovf`=0, `out_rem_err`=0, digit counter=0, carry=0.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid & in_ready`:
    - latch `in_q` into the shift register;
    - carry ← `in_r`;
    - `rem_err` ← (`in_r >= DIVISOR`);
    - counter ← 0;
    - go to RUN.
- **RUN**
  - `in_ready`=0.
  - Each cycle compute `acc = q[CHUNK-1:0]*DIVISOR + carry` (12 bits is sufficient).
  - The digit `acc[CHUNK-1:0]` shifts into `out_x` from the MSB side; `q` shifts right by `CHUNK`.
  - carry ← `acc >> CHUNK`. Carry ≤ 63 always holds, so it fits in `CHUNK` bits.
  - When the counter reaches `W/CHUNK-1`:
    - `out_ovf` ← (final carry ≠ 0);
    - go to DONE.
- **DONE**
  - `out_valid`=1; `out_x`, `out_ovf` and `out_rem_err` are held stable.
  - On `out_ready`: go to IDLE and drop `out_valid` on the next cycle.
  - No new request is accepted while in DONE.
- `out_rem_err` is informational only. The arithmetic is still performed with the given `r`.
- Reset mid-RUN or mid-DONE: return to IDLE immediately (asynchronously) and discard the result; no `out_valid` pulse occurs.
- `in_q`/`in_r` changes after the accept edge have no effect.

## Timing
- Accept edge E0. RUN occupies edges E1..E10 (`W/CHUNK` = 10 digits).
- `out_valid` is high from after E10 until the edge on which `out_ready` is sampled high.
- Latency from accept to `out_valid`: 10 cycles.
- Minimum request spacing: 12 cycles (accept, 10 × RUN, 1 × DONE with `out_ready`=1, then IDLE).
- `in_ready` is a registered function of state. Nothing combinational runs from inputs to `in_ready`/`out_valid`.
- `out_x` is undefined while in RUN; the bench must only sample it while `out_valid`=1.

## Structure
- Package `const_div_pkg`: `W`, `CHUNK`, `DIVISOR`, `NDIG = W/CHUNK`, `state_t` enum (IDLE/RUN/DONE), digit and carry typedefs.
- Sub-module `chunk_mac_47`: purely combinational, `(digit, carry_in) → (digit_out, carry_out)` for the constant multiply-accumulate. It pairs with the divider's per-chunk LUT slices.
- Top-level: FSM, counter, `q` shift register, result shift register.

## Test plan
- `q=0`, `r=0` → `out_x=0`, `ovf=0`, `rem_err=0`; `out_valid` rises exactly 10 cycles after the accept.
- `q=1`, `r=46` → `out_x=93`, `ovf=0`.
- `q=24530244778869084`, `r=27` → `out_x = 2**60-1` (1152921504606846975), `ovf=0`.
- `q=24530244778869085`, `r=0` → `ovf=1`, `out_x=19`.
- `q=5`, `r=50` → `rem_err=1`, `out_x=285`, `ovf=0`.
- Hold `out_ready=0` for 5 cycles in DONE → outputs stable and `in_ready=0` throughout; accept completes on the `out_ready` edge. Separately, assert `rst_n` low during RUN digit 4 → `out_valid` never pulses, `in_ready=1` after release.

Source files
------------

// File: rtl/const_div_pkg.sv
// Shared constants and types for the divide-by-47 slice and its reconstruction inverse.
// Pure declarations: no latency, no flow control.
// Digit and carry widths both equal CHUNK because the carry can never exceed 63.
package const_div_pkg;

    localparam int W       = 60;
    localparam int CHUNK   = 6;
    localparam int DIVISOR = 47;
    localparam int NDIG    = W / CHUNK;
    localparam int CNT_W   = $clog2(NDIG);

    typedef logic [CHUNK-1:0] digit_t;
    typedef logic [CHUNK-1:0] carry_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/chunk_mac_47.sv
// One digit of the constant multiply-accumulate: digit*DIVISOR + carry.
// Combinational, zero latency; no flow control.
// Splits the 2*CHUNK-bit sum into the output digit and the next carry.
module chunk_mac_47 #(
    parameter int CHUNK   = const_div_pkg::CHUNK,
    parameter int DIVISOR = const_div_pkg::DIVISOR
) (
    input  logic [CHUNK-1:0] digit_i,
    input  logic [CHUNK-1:0] carry_i,
    output logic [CHUNK-1:0] digit_o,
    output logic [CHUNK-1:0] carry_o
);

    localparam logic [2*CHUNK-1:0] DIV_W = (2*CHUNK)'(DIVISOR);

    logic [2*CHUNK-1:0] acc;

    always_comb begin
        acc = {{CHUNK{1'b0}}, digit_i} * DIV_W + {{CHUNK{1'b0}}, carry_i};
    end

    assign digit_o = acc[CHUNK-1:0];
    assign carry_o = acc[2*CHUNK-1:CHUNK];

endmodule

// File: rtl/const_mul_recon_47.sv
// Rebuilds x = q*DIVISOR + r digit-serially, CHUNK bits per cycle, LSB first.
// Latency W/CHUNK cycles from accept to out_valid; one request in flight.
// in_ready only in IDLE; result held in DONE until out_ready is sampled high.
module const_mul_recon_47 #(
    parameter int W       = const_div_pkg::W,
    parameter int CHUNK   = const_div_pkg::CHUNK,
    parameter int DIVISOR = const_div_pkg::DIVISOR
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_q,
    input  logic [CHUNK-1:0] in_r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_x,
    output logic             out_ovf,
    output logic             out_rem_err
);

    import const_div_pkg::*;

    localparam int                ND    = W / CHUNK;
    localparam int                CW    = (ND > 1) ? $clog2(ND) : 1;
    localparam logic [CW-1:0]     LAST  = CW'(ND - 1);
    localparam logic [CHUNK-1:0]  DIV_C = CHUNK'(DIVISOR);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W-1:0]     q_q, q_d;
    logic [W-1:0]     x_q, x_d;
    logic [CHUNK-1:0] carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             rerr_q, rerr_d;

    logic [CHUNK-1:0] mac_digit;
    logic [CHUNK-1:0] mac_carry;

    chunk_mac_47 #(
        .CHUNK   (CHUNK),
        .DIVISOR (DIVISOR)
    ) u_mac (
        .digit_i (q_q[CHUNK-1:0]),
        .carry_i (carry_q),
        .digit_o (mac_digit),
        .carry_o (mac_carry)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        x_d     = x_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        rerr_d  = rerr_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Remainder seeds the carry so the "+ r" costs no extra cycle.
                    q_d     = in_q;
                    carry_d = in_r;
                    rerr_d  = (in_r >= DIV_C);
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                x_d     = {mac_digit, x_q[W-1:CHUNK]};
                q_d     = q_q >> CHUNK;
                carry_d = mac_carry;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    ovf_d   = (mac_carry != '0);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            x_q     <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            x_q     <= x_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            rerr_q  <= rerr_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign out_x       = x_q;
    assign out_ovf     = ovf_q;
    assign out_rem_err = rerr_q;

endmodule

// File: tb/tb_const_mul_recon_47.sv
// Scoreboard bench for const_mul_recon_47: expected results come from plain q*47+r arithmetic.
// Stimulus pushes expectations; a negedge monitor pops and compares on every output handshake.
module tb_const_mul_recon_47;

    localparam int W   = 60;
    localparam int CH  = 6;
    localparam int LAT = 10;

    typedef struct {
        logic [W-1:0] x;
        logic         ovf;
        logic         rerr;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_q = '0;
    logic [CH-1:0] in_r = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_x;
    logic          out_ovf;
    logic          out_rem_err;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   rdy_mode = 0;
    exp_t sb[$];

    const_mul_recon_47 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_q        (in_q),
        .in_r        (in_r),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_x       (out_x),
        .out_ovf     (out_ovf),
        .out_rem_err (out_rem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] q, input logic [CH-1:0] r);
        logic [W+9:0] full;
        exp_t e;
        full   = (W+10)'(q) * (W+10)'(47) + (W+10)'(r);
        e.x    = full[W-1:0];
        e.ovf  = (full[W+9:W] != 0);
        e.rerr = (r >= 6'd47);
        return e;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && in_valid && in_ready) acc_cyc <= cyc + 1;
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    logic ov_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            ov_prev = 1'b0;
        end else begin
            if (out_valid && !ov_prev) begin
                if (sb.size() == 0) chk("spurious_out_valid", 64'(out_valid), 64'd0);
                else                chk("latency", 64'(cyc - acc_cyc), 64'(LAT));
            end
            if (out_valid && sb.size() > 0) begin
                e = sb[0];
                if (!out_ready) begin
                    chk("hold_out_x", 64'(out_x), 64'(e.x));
                    chk("hold_in_ready", 64'(in_ready), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("out_x", 64'(out_x), 64'(e.x));
                    chk("out_ovf", 64'(out_ovf), 64'(e.ovf));
                    chk("out_rem_err", 64'(out_rem_err), 64'(e.rerr));
                end
            end
            ov_prev = out_valid;
        end
    end

    // Called at posedge+1; in_q/in_r are scrambled right after the accept edge.
    task automatic send(input logic [W-1:0] q, input logic [CH-1:0] r, input bit push);
        int t = 0;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1; t++;
        end
        if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_q     = q;
        in_r     = r;
        if (push) sb.push_back(model(q, r));
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_q     = W'({$urandom, $urandom});
        in_r     = CH'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 2000) begin
            @(posedge clk); #1; t++;
        end
        if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] q;
        #3;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_x", 64'(out_x), 64'd0);
        chk("rst_out_ovf", 64'(out_ovf), 64'd0);
        chk("rst_out_rem_err", 64'(out_rem_err), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        send(60'd0, 6'd0, 1'b1);                    drain();
        send(60'd1, 6'd46, 1'b1);                   drain();
        send(60'd24530244778869084, 6'd27, 1'b1);   drain();
        send(60'd24530244778869085, 6'd0, 1'b1);    drain();
        send(60'd5, 6'd50, 1'b1);                   drain();

        // Stall the consumer for five cycles in DONE.
        rdy_mode = 1;
        send(60'd123456789, 6'd13, 1'b1);
        for (int t = 0; t < 100 && !out_valid; t++) begin
            @(posedge clk); #1;
        end
        chk("stall_reached_done", 64'(out_valid), 64'd1);
        repeat (5) @(posedge clk);
        #1;
        rdy_mode = 0;
        drain();

        // Reset during RUN digit 4 must discard the result.
        send(60'd987654321, 6'd7, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_out_valid", 64'(out_valid), 64'd0);
        chk("midrun_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        repeat (15) @(posedge clk);
        #1;
        chk("post_rst_in_ready_later", 64'(in_ready), 64'd1);
        send(60'd1, 6'd46, 1'b1);                   drain();

        rdy_mode = 2;
        for (int i = 0; i < 40; i++) begin
            case (i % 4)
                0:       q = '1;
                1:       q = W'($urandom_range(0, 1000));
                default: q = W'({$urandom, $urandom});
            endcase
            send(q, CH'($urandom_range(0, 63)), 1'b1);
        end
        rdy_mode = 0;
        drain();
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
